// File: rtl/dct_coeff_rle.sv
// Float DCT coefficient -> saturated integer level -> zero-run (run, level, EOB) tokens.
// Optional: define DCT_RLE_SAT_FLAG_EN to add a per-block saturation flag on the EOB token.
module dct_coeff_rle #(
  parameter int DCT_POINT = 16,
  parameter int M         = 23,
  parameter int E         = 8,
  parameter int W         = 12,
  parameter int QSH       = 0,
  parameter int RUNW      = $clog2(DCT_POINT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [M+E:0]        inp,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [RUNW-1:0]     out_run,
  output logic signed [W-1:0] out_level,
  output logic                out_eob,
  output logic                out_valid,
  input  logic                out_ready
`ifdef DCT_RLE_SAT_FLAG_EN
  ,
  output logic                sat_flag
`endif
);

  localparam int BIAS = 2**(E-1) - 1;
  localparam int FW   = M + 1 + W;
  localparam logic [W:0]      MAXL = {2'b00, {(W-1){1'b1}}};
  localparam logic [RUNW-1:0] LAST = RUNW'(DCT_POINT - 1);

  typedef enum logic {ACCEPT, EOB_PEND} state_t;

  logic                w_sign;
  logic [E-1:0]        w_exp;
  logic [M-1:0]        w_man;
  logic signed [31:0]  w_t;
  logic [FW-1:0]       w_ext;
  logic [W:0]          w_x2;
  logic [W:0]          w_raw;
  logic [W:0]          w_mag;
  logic                w_ovf;
  logic signed [W-1:0] w_level;
  logic                w_nz;

  assign {w_sign, w_exp, w_man} = inp;
  // w_t is one more than the unbiased exponent: twice the value has t integer bits
  assign w_t   = $signed(32'(w_exp)) - BIAS - QSH + 1;
  assign w_ext = {1'b1, w_man, {W{1'b0}}};

  always_comb begin
    w_x2  = '0;
    w_raw = '0;
    w_ovf = 1'b0;
    if (w_exp == '1) begin
      w_ovf = (w_man == '0);
    end else if (w_exp != '0) begin
      if (w_t >= W) begin
        w_ovf = 1'b1;
      end else if (w_t >= 0) begin
        w_x2  = (W+1)'(w_ext >> (M + W - w_t));
        w_raw = (w_x2 + 1'b1) >> 1;
        w_ovf = (w_raw > MAXL);
      end
    end
  end

  assign w_mag   = w_ovf ? MAXL : w_raw;
  assign w_level = w_sign ? -$signed(w_mag[W-1:0])
                          : $signed(w_mag[W-1:0]);
  assign w_nz    = (w_level != '0);

  state_t              r_state, w_state_n;
  logic [RUNW-1:0]     r_idx, w_idx_n;
  logic [RUNW-1:0]     r_run, w_run_n;
  logic [RUNW-1:0]     r_orun, w_orun_n;
  logic signed [W-1:0] r_olvl, w_olvl_n;
  logic                r_oeob, w_oeob_n;
  logic                r_ovld, w_ovld_n;
`ifdef DCT_RLE_SAT_FLAG_EN
  logic                r_stk, w_stk_n;
  logic                r_osat, w_osat_n;
`endif
  logic                w_acc;
  logic                w_cons;

  assign in_ready = reset & (r_state == ACCEPT) & (~r_ovld | out_ready);
  assign w_acc    = in_valid & in_ready;
  assign w_cons   = r_ovld & out_ready;

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_run_n   = r_run;
    w_orun_n  = r_orun;
    w_olvl_n  = r_olvl;
    w_oeob_n  = r_oeob;
    w_ovld_n  = r_ovld;
`ifdef DCT_RLE_SAT_FLAG_EN
    w_stk_n   = r_stk;
    w_osat_n  = r_osat;
`endif
    if (w_cons) begin
      w_ovld_n = 1'b0;
`ifdef DCT_RLE_SAT_FLAG_EN
      if (r_oeob) w_stk_n = 1'b0;
`endif
      if (r_state == EOB_PEND) begin
        w_ovld_n  = 1'b1;
        w_orun_n  = '0;
        w_olvl_n  = '0;
        w_oeob_n  = 1'b1;
        w_state_n = ACCEPT;
`ifdef DCT_RLE_SAT_FLAG_EN
        w_osat_n  = r_stk;
`endif
      end
    end
    if (w_acc) begin
`ifdef DCT_RLE_SAT_FLAG_EN
      w_stk_n  = w_stk_n | w_ovf;
      w_osat_n = 1'b0;
`endif
      if (r_idx == LAST) begin
        w_idx_n  = '0;
        w_run_n  = '0;
        w_ovld_n = 1'b1;
        if (w_nz) begin
          w_orun_n  = r_run;
          w_olvl_n  = w_level;
          w_oeob_n  = 1'b0;
          w_state_n = EOB_PEND;
        end else begin
          // trailing zeros collapse straight into the EOB token
          w_orun_n = '0;
          w_olvl_n = '0;
          w_oeob_n = 1'b1;
`ifdef DCT_RLE_SAT_FLAG_EN
          w_osat_n = w_stk_n;
`endif
        end
      end else begin
        w_idx_n = r_idx + 1'b1;
        if (r_idx == '0 || w_nz) begin
          w_ovld_n = 1'b1;
          w_orun_n = (r_idx == '0) ? '0 : r_run;
          w_olvl_n = w_level;
          w_oeob_n = 1'b0;
          w_run_n  = '0;
        end else begin
          w_run_n = r_run + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ACCEPT;
      r_idx   <= '0;
      r_run   <= '0;
      r_orun  <= '0;
      r_olvl  <= '0;
      r_oeob  <= 1'b0;
      r_ovld  <= 1'b0;
`ifdef DCT_RLE_SAT_FLAG_EN
      r_stk   <= 1'b0;
      r_osat  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_run   <= w_run_n;
      r_orun  <= w_orun_n;
      r_olvl  <= w_olvl_n;
      r_oeob  <= w_oeob_n;
      r_ovld  <= w_ovld_n;
`ifdef DCT_RLE_SAT_FLAG_EN
      r_stk   <= w_stk_n;
      r_osat  <= w_osat_n;
`endif
    end
  end

  assign out_run   = r_orun;
  assign out_level = r_olvl;
  assign out_eob   = r_oeob;
  assign out_valid = r_ovld;
`ifdef DCT_RLE_SAT_FLAG_EN
  assign sat_flag  = r_osat;
`endif

endmodule

// File: tb/tb_dct_coeff_rle.sv
// Scoreboard bench for dct_coeff_rle: float-level reference model, random and directed blocks.
// Checks sat_flag too when DCT_RLE_SAT_FLAG_EN is defined.
module tb_dct_coeff_rle;
  localparam int N   = 16;
  localparam int W   = 12;
  localparam int RW  = 4;
  localparam int QSH = 0;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [31:0]         inp = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [RW-1:0]       out_run;
  logic signed [W-1:0] out_level;
  logic                out_eob;
  logic                out_valid;
  logic                out_ready = 1'b1;
`ifdef DCT_RLE_SAT_FLAG_EN
  logic                sat_flag;
`endif

  always #5 clk = ~clk;

  dct_coeff_rle dut (
    .clk(clk),
    .reset(reset),
    .inp(inp),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_run(out_run),
    .out_level(out_level),
    .out_eob(out_eob),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DCT_RLE_SAT_FLAG_EN
    ,
    .sat_flag(sat_flag)
`endif
  );

  typedef struct {
    int run;
    int level;
    bit eob;
    bit sat;
  } tok_t;

  tok_t q[$];
  int   blk[$];
  bit   blk_sat;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ready_mode = 0;
  int   cyc = 0;
  int   stall_from = -10;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // value of the float, rounded half away from zero and clamped to the level range
  function automatic int ref_level(input logic [31:0] f, output bit sat);
    int  e;
    int  mag;
    real v;
    e   = int'(f[30:23]);
    sat = 1'b0;
    if (e == 0) return 0;
    if (e == 255) begin
      if (f[22:0] != 0) return 0;
      sat = 1'b1;
      return f[31] ? -2047 : 2047;
    end
    v = 1.0 + real'(int'(f[22:0])) / 8388608.0;
    for (int k = 0; k < e - 127 - QSH; k++) v = v * 2.0;
    for (int k = 0; k < 127 + QSH - e; k++) v = v / 2.0;
    if (v >= 2047.5) begin
      sat = 1'b1;
      mag = 2047;
    end else begin
      mag = int'($floor(v + 0.5));
    end
    return f[31] ? -mag : mag;
  endfunction

  function automatic void model_accept(input logic [31:0] f);
    bit s;
    int lv;
    int k;
    int run;
    lv = ref_level(f, s);
    blk_sat = blk_sat | s;
    k = blk.size();
    blk.push_back(lv);
    if (k == 0) begin
      q.push_back('{0, lv, 1'b0, 1'b0});
    end else if (lv != 0) begin
      run = 0;
      for (int j = k - 1; j >= 1 && blk[j] == 0; j--) run++;
      q.push_back('{run, lv, 1'b0, 1'b0});
    end
    if (k == N - 1) begin
      q.push_back('{0, 0, 1'b1, blk_sat});
      blk.delete();
      blk_sat = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rnd_float();
    logic [31:0] sp [5];
    int r;
    sp[0] = 32'h7F800000;
    sp[1] = 32'hFF800000;
    sp[2] = 32'h7FC00001;
    sp[3] = 32'h00012345;
    sp[4] = 32'h80000000;
    r = $urandom % 8;
    if (r < 4) return 32'h0;
    if (r < 6)
      return {1'($urandom), 8'($urandom_range(136, 118)), 23'($urandom)};
    if (r == 6)
      return {1'($urandom), 8'($urandom_range(150, 137)), 23'($urandom)};
    return sp[$urandom % 5];
  endfunction

  task automatic send(input logic [31:0] f, output int waits);
    waits = 0;
    @(negedge clk);
    inp = f;
    in_valid = 1'b1;
    #1;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL input_timeout: in_ready got 0 expected 1");
      in_valid = 1'b0;
      return;
    end
    model_accept(f);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] c [N], output int first_waits);
    int w;
    for (int i = 0; i < N; i++) begin
      send(c[i], w);
      if (i == 0) first_waits = w;
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      #2;
      if (reset && out_valid) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_token: run %0d level %0d eob %0d expected none",
                   out_run, out_level, out_eob);
        end else begin
          check("tok_run", int'(out_run), q[0].run);
          check("tok_level", int'(out_level), q[0].level);
          check("tok_eob", int'(out_eob), int'(q[0].eob));
`ifdef DCT_RLE_SAT_FLAG_EN
          check("tok_sat", int'(sat_flag), int'(q[0].sat));
`endif
          if (out_ready) void'(q.pop_front());
          else check("in_ready_stall", int'(in_ready), 0);
        end
      end
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc >= stall_from && cyc < stall_from + 3) out_ready = 1'b0;
      else if (ready_mode == 1) out_ready = ($urandom % 4) != 0;
      else out_ready = 1'b1;
    end
  endtask

  logic [31:0] b1 [N];
  logic [31:0] b2 [N];
  logic [31:0] b3 [N];
  logic [31:0] br [N];
  int w;

  initial begin
    blk_sat = 1'b0;
    foreach (b1[i]) begin
      b1[i] = '0;
      b2[i] = '0;
      b3[i] = '0;
    end
    b1[0] = 32'h41200000;
    b1[5] = 32'hBF800000;
    b2[0] = 32'h40200000;
    b2[1] = 32'hC0200000;
    b2[2] = 32'h3F000000;
    b2[3] = 32'h3EFFFFFF;
    b2[4] = 32'h80000000;
    b2[6] = 32'h459C4000;
    b2[8] = 32'hFF800000;
    b2[9] = 32'h7FC00000;
    b3[0] = 32'h40000000;
    b3[15] = 32'h3F800000;

    fork
      monitor_loop();
      ready_loop();
    join_none

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_run", int'(out_run), 0);
    check("rst_out_level", int'(out_level), 0);
    check("rst_out_eob", int'(out_eob), 0);
    check("rst_in_ready", int'(in_ready), 0);
    @(negedge clk);
    reset = 1'b1;

    send_block(b1, w);
    send_block(b2, w);
    check("eob_direct_no_bubble", w, 0);
    send_block(b3, w);
    send_block(b1, w);
    check("eob_pend_bubble", w, 1);

    stall_from = cyc + 1;
    send_block(b1, w);
    check("stall_waits", w, 3);

    for (int i = 0; i < 7; i++) begin
      send(rnd_float(), w);
    end
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    blk.delete();
    blk_sat = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_out_valid", int'(out_valid), 0);
    send_block(b1, w);

    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      foreach (br[i]) br[i] = rnd_float();
      if (n % 3 == 0) br[N-1] = {1'($urandom), 8'd127, 23'($urandom)};
      send_block(br, w);
    end

    ready_mode = 0;
    for (int t = 0; t < 200 && (q.size() != 0 || out_valid); t++)
      @(negedge clk);
    #3;
    check("drain_queue_empty", q.size(), 0);
    check("drain_out_valid", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
